// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the adder arbiter: FSM state encoding,
// float width and the grant-index width function.
package adder_arb_pkg;
  localparam int FLOAT_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    RESP   = 3'd4
  } state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/adder_arbiter_if.sv
// Requester and adder handshake bundle. The slave modport is the arbiter;
// the master modport is the environment (requesters plus the FP adder).
interface adder_arbiter_if #(parameter int NREQ = 4);
  import adder_arb_pkg::*;

  logic [NREQ-1:0]         req_stb, req_ack, req_op;
  logic [FLOAT_W*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]         rsp_stb, rsp_ack;
  logic [FLOAT_W-1:0]      rsp_z;
  logic [FLOAT_W-1:0]      adder_a, adder_b, adder_z;
  logic                    adder_a_stb, adder_a_ack;
  logic                    adder_b_stb, adder_b_ack;
  logic                    adder_z_stb, adder_z_ack;

  modport slave (
    input  req_stb, req_a, req_b, req_op, rsp_ack,
           adder_a_ack, adder_b_ack, adder_z, adder_z_stb,
    output req_ack, rsp_stb, rsp_z,
           adder_a, adder_b, adder_a_stb, adder_b_stb, adder_z_ack
  );

  modport master (
    output req_stb, req_a, req_b, req_op, rsp_ack,
           adder_a_ack, adder_b_ack, adder_z, adder_z_stb,
    input  req_ack, rsp_stb, rsp_z,
           adder_a, adder_b, adder_a_stb, adder_b_stb, adder_z_ack
  );
endinterface

// File: rtl/adder_arbiter_rr.sv
// Combinational round-robin pick: searches upward from last_grant+1 with
// wrap-around and returns the first requesting index.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]          req,
  input  logic [idx_w(NREQ)-1:0]   last_grant,
  output logic [idx_w(NREQ)-1:0]   grant,
  output logic                     valid
);
  localparam int IW = idx_w(NREQ);

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_grant) + k) % NREQ;
      if (req[idx]) begin
        valid = 1'b1;
        grant = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/adder_arbiter.sv
// Shares one non-pipelined FP adder among NREQ requesters, one transaction
// at a time. Define ADDER_ARB_SUB_EN to honour req_op (subtract by B sign flip).
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  adder_arbiter_if.slave  bus,
  output logic            busy
);
  localparam int IW = idx_w(NREQ);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_SEND_A = SEND_A;
  localparam logic [2:0] S_SEND_B = SEND_B;
  localparam logic [2:0] S_WAIT_Z = WAIT_Z;
  localparam logic [2:0] S_RESP   = RESP;

  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic               ack_q, ack_d;
  logic [FLOAT_W-1:0] z_q, z_d;
  logic [FLOAT_W-1:0] a_q, a_d, b_q, b_d;
  logic               op_q, op_d;

  logic [IW-1:0]      pick_idx;
  logic               pick_vld;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (bus.req_stb),
    .last_grant (last_q),
    .grant      (pick_idx),
    .valid      (pick_vld)
  );

  always_comb begin
    int sel;
    sel     = FLOAT_W * int'(pick_idx);
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack_d   = 1'b0;
    z_d     = z_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: if (pick_vld) begin
        grant_d = pick_idx;
        a_d     = bus.req_a[sel +: FLOAT_W];
        b_d     = bus.req_b[sel +: FLOAT_W];
        op_d    = bus.req_op[pick_idx];
        ack_d   = 1'b1;
        state_d = S_SEND_A;
      end
      S_SEND_A: if (bus.adder_a_ack) state_d = S_SEND_B;
      S_SEND_B: if (bus.adder_b_ack) state_d = S_WAIT_Z;
      S_WAIT_Z: if (bus.adder_z_stb) begin
        z_d     = bus.adder_z;
        state_d = S_RESP;
      end
      S_RESP: if (bus.rsp_ack[grant_q]) begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, including the result register which must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
      ack_q   <= 1'b0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      z_q     <= z_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  always_comb begin
    bus.req_ack = '0;
    bus.rsp_stb = '0;
    if (ack_q) bus.req_ack[grant_q] = 1'b1;
    if (state_q == S_RESP) bus.rsp_stb[grant_q] = 1'b1;
  end

  assign bus.rsp_z       = z_q;
  assign bus.adder_a     = a_q;
  assign bus.adder_a_stb = (state_q == S_SEND_A);
  assign bus.adder_b_stb = (state_q == S_SEND_B);
  assign bus.adder_z_ack = (state_q == S_WAIT_Z);
  assign busy            = (state_q != S_IDLE);

`ifdef ADDER_ARB_SUB_EN
  assign bus.adder_b = op_q ? {~b_q[FLOAT_W-1], b_q[FLOAT_W-2:0]} : b_q;
`else
  logic unused_op;
  assign unused_op   = op_q;
  assign bus.adder_b = b_q;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a small table-driven FP adder stub.
module tb_adder_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   z_delay = 1;

  adder_arbiter_if #(.NREQ(4)) bus ();

  adder_arbiter #(.NREQ(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Adder stub: accepts operands immediately, answers after z_delay cycles.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 32'hFFC00000;
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40400000, 32'hBF800000}: return 32'h40000000;
      {32'h40400000, 32'h3F800000}: return 32'h40800000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  logic [31:0] m_a, m_b;
  logic        m_busy;
  int          m_cnt;

  assign bus.adder_a_ack = bus.adder_a_stb;
  assign bus.adder_b_ack = bus.adder_b_stb;

  always @(posedge clk) begin
    if (rst) begin
      m_busy          <= 1'b0;
      m_cnt           <= 0;
      bus.adder_z_stb <= 1'b0;
      bus.adder_z     <= '0;
    end else begin
      if (bus.adder_a_stb && bus.adder_a_ack) m_a <= bus.adder_a;
      if (bus.adder_b_stb && bus.adder_b_ack) begin
        m_b    <= bus.adder_b;
        m_cnt  <= z_delay;
        m_busy <= 1'b1;
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          bus.adder_z_stb <= 1'b1;
          bus.adder_z     <= fp_add(m_a, m_b);
          m_busy          <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (bus.adder_z_stb && bus.adder_z_ack) bus.adder_z_stb <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // which: 0 = req_ack, 1 = rsp_stb, 2 = adder_z_ack
  task automatic wait_sig(input int which, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      case (which)
        0:       hit = (bus.req_ack != 0);
        1:       hit = (bus.rsp_stb != 0);
        default: hit = bus.adder_z_ack;
      endcase
      if (!hit) @(negedge clk);
    end
    n_tests++;
    assert (hit) else begin
      n_fail++;
      $error("FAIL %s: observed no event, expected event within 64 cycles", tag);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_op[i]         = op;
    bus.req_stb[i]        = 1'b1;
  endtask

  task automatic do_reset();
    bus.req_stb = '0;
    bus.rsp_ack = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(busy),            32'h0);
    chk({tag, "_rack"},  32'(bus.req_ack),     32'h0);
    chk({tag, "_rstb"},  32'(bus.rsp_stb),     32'h0);
    chk({tag, "_astb"},  32'(bus.adder_a_stb), 32'h0);
    chk({tag, "_bstb"},  32'(bus.adder_b_stb), 32'h0);
    chk({tag, "_zack"},  32'(bus.adder_z_ack), 32'h0);
    chk({tag, "_rspz"},  bus.rsp_z,            32'h0);
  endtask

  // Wait for response, check it, then acknowledge for one cycle.
  task automatic finish_rsp(input int i, input logic [31:0] exp, input string tag);
    wait_sig(1, {tag, "_rsp_wait"});
    chk({tag, "_rsp_stb"}, 32'(bus.rsp_stb), 32'(1 << i));
    chk({tag, "_rsp_z"},   bus.rsp_z,        exp);
    bus.rsp_ack[i] = 1'b1;
    @(negedge clk);
    bus.rsp_ack[i] = 1'b0;
    chk({tag, "_rsp_drop"}, 32'(bus.rsp_stb), 32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.req_stb = '0;
    bus.req_a   = '0;
    bus.req_b   = '0;
    bus.req_op  = '0;
    bus.rsp_ack = '0;
    @(negedge clk);
    do_reset();
    chk_idle("reset");

    // Single request 1.0 + 2.0
    set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    @(negedge clk);
    chk("single_ack", 32'(bus.req_ack), 32'h1);
    chk("single_busy", 32'(busy), 32'h1);
    bus.req_stb[0] = 1'b0;
    @(negedge clk);
    chk("single_ack_pulse", 32'(bus.req_ack), 32'h0);
    finish_rsp(0, 32'h40400000, "single");
    chk("single_idle_busy", 32'(busy), 32'h0);

    // All four simultaneously after reset: grants 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h3F800000, 32'h3F800000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_sig(0, "rr_ack_wait");
      chk("rr_ack", 32'(bus.req_ack), 32'(1 << i));
      bus.req_stb[i] = 1'b0;
      finish_rsp(i, 32'h40000000, "rr");
    end

    // Subtract operation on requester 2: 3.0 op 1.0
    set_req(2, 32'h40400000, 32'h3F800000, 1'b1);
    wait_sig(0, "sub_ack_wait");
    chk("sub_ack", 32'(bus.req_ack), 32'h4);
    bus.req_stb[2] = 1'b0;
`ifdef ADDER_ARB_SUB_EN
    finish_rsp(2, 32'h40000000, "sub");
`else
    finish_rsp(2, 32'h40800000, "sub");
`endif

    // Held response with a competing request and a stray rsp_ack
    set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    wait_sig(0, "hold_ack_wait");
    chk("hold_ack0", 32'(bus.req_ack), 32'h1);
    bus.req_stb[0] = 1'b0;
    set_req(1, 32'h3F800000, 32'h3F800000, 1'b0);
    wait_sig(1, "hold_rsp_wait");
    bus.rsp_ack[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("hold_rsp_stb", 32'(bus.rsp_stb), 32'h1);
      chk("hold_rsp_z",   bus.rsp_z,        32'h40400000);
      chk("hold_no_ack",  32'(bus.req_ack), 32'h0);
      @(negedge clk);
    end
    bus.rsp_ack[2] = 1'b0;
    bus.rsp_ack[0] = 1'b1;
    @(negedge clk);
    bus.rsp_ack[0] = 1'b0;
    chk("hold_rsp_drop", 32'(bus.rsp_stb), 32'h0);
    wait_sig(0, "hold_ack1_wait");
    chk("hold_ack1", 32'(bus.req_ack), 32'h2);
    bus.req_stb[1] = 1'b0;
    finish_rsp(1, 32'h40000000, "hold1");

    // Reset while waiting on the adder
    z_delay = 5;
    set_req(3, 32'h3F800000, 32'h3F800000, 1'b0);
    wait_sig(0, "rstz_ack_wait");
    chk("rstz_ack", 32'(bus.req_ack), 32'h8);
    bus.req_stb[3] = 1'b0;
    wait_sig(2, "rstz_zack_wait");
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rstz");
    rst = 1'b0;
    z_delay = 1;
    repeat (8) begin
      @(negedge clk);
      chk("rstz_no_rsp", 32'(bus.rsp_stb), 32'h0);
    end
    set_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
    wait_sig(0, "rstz_next_wait");
    chk("rstz_next_ack", 32'(bus.req_ack), 32'h1);
    bus.req_stb[0] = 1'b0;
    finish_rsp(0, 32'h40000000, "rstz_next");

    // NaN operand passes to the adder and its NaN comes back unchanged
    set_req(1, 32'h7FC00000, 32'h3F800000, 1'b0);
    wait_sig(0, "nan_ack_wait");
    chk("nan_ack", 32'(bus.req_ack), 32'h2);
    bus.req_stb[1] = 1'b0;
    finish_rsp(1, 32'hFFC00000, "nan");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing one FP adder (2..8).
REQ-002 Port: clk  in  1  single clock; all logic on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: req_stb  in  NREQ  per-requester operation valid; held with operands until req_ack.
REQ-005 Port: req_ack  out  NREQ  one-cycle pulse: operands captured.
REQ-006 Port: req_a  in  32*NREQ  operand A, requester i at [32i+31:32i].
REQ-007 Port: req_b  in  32*NREQ  operand B, same packing.
REQ-008 Port: req_op  in  NREQ  0 = add, 1 = subtract (see Configuration).
REQ-009 Port: rsp_stb  out  NREQ  result valid to the granted requester; held until rsp_ack.
REQ-010 Port: rsp_ack  in  NREQ  requester consumes result.
REQ-011 Port: rsp_z  out  32  shared result bus, valid while any rsp_stb bit is high.
REQ-012 Ports: adder_a/adder_b  out  32; adder_a_stb/adder_b_stb  out  1; adder_a_ack/adder_b_ack  in  1; adder_z  in  32; adder_z_stb  in  1; adder_z_ack  out  1; connect to the team's single-precision adder.
REQ-013 Port: busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, SEND_A, SEND_B, WAIT_Z, RESP; one transaction in flight (adder not pipelined).
REQ-015 IDLE: if any req_stb, pick grant g round-robin from last_grant+1 upward with wrap-around; capture req_a[g], req_b[g], req_op[g]; next cycle req_ack[g]=1 for exactly one cycle; go to SEND_A.
REQ-016 SEND_A: adder_a_stb=1, adder_a=captured A; transfer on cycle with adder_a_stb && adder_a_ack; next cycle adder_a_stb=0; go to SEND_B.
REQ-017 SEND_B: same rule with adder_b_stb/adder_b_ack; then WAIT_Z.
REQ-018 WAIT_Z: adder_z_ack=1; on adder_z_stb && adder_z_ack capture adder_z, drop adder_z_ack next cycle, go to RESP.
REQ-019 RESP: rsp_stb[g]=1, rsp_z=captured result; on rsp_ack[g] clear rsp_stb, set last_grant=g, return to IDLE.
REQ-020 At most one bit of req_ack, rsp_stb high in any cycle; rsp_ack bits for non-granted requesters and rsp_ack outside RESP are ignored.
REQ-021 req_stb from non-granted requesters while busy produces no ack; requests stay pending and compete at next IDLE.
REQ-022 Minimum latency req_stb to rsp_stb = 4 cycles plus adder compute time; back-to-back transactions: no idle cycle beyond the one IDLE cycle.
REQ-023 Fairness: with all requesters continuously requesting, grants cycle 0,1,...,NREQ-1,0.
REQ-024 Operands and results pass through bit-exact (NaN, Inf, denormal, ±0 untouched) except the sign flip of REQ-030.

Reset
REQ-025 rst in any state: state=IDLE, req_ack=0, rsp_stb=0, adder_a_stb=0, adder_b_stb=0, adder_z_ack=0, busy=0, rsp_z=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-026 Reset mid-transaction discards the transaction; no rsp_stb issued for it; the adder shares the same rst.
REQ-027 rst takes priority over every other event in the same cycle.

Configuration
REQ-028 Macro ADDER_ARB_SUB_EN enables subtraction.
REQ-029 Without it: req_op ignored, adder_b = captured B.
REQ-030 With it: when captured op=1, adder_b = {~B[31], B[30:0]}, giving A − B.

Structure
REQ-031 Package adder_arb_pkg: FSM state enum, FLOAT_W=32, IDX width function for NREQ.
REQ-032 Sub-module rr_arbiter: combinational round-robin pick (request vector, last_grant → grant index, valid).

Verification
REQ-033 Single request: req 0, A=0x3F800000, B=0x40000000 → req_ack[0] one cycle later, rsp_z=0x40400000 (3.0) on rsp_stb[0].
REQ-034 All four request simultaneously after reset, each A=0x3F800000, B=0x3F800000 → grants in order 0,1,2,3, each rsp_z=0x40000000.
REQ-035 With ADDER_ARB_SUB_EN: A=0x40400000, B=0x3F800000, op=1 → rsp_z=0x40000000; without macro same stimulus → 0x40800000.
REQ-036 rsp_ack withheld 10 cycles in RESP → rsp_stb and rsp_z stable, req 1 pending gets no req_ack until after rsp_ack[0].
REQ-037 rst asserted during WAIT_Z → all outputs at reset values next cycle, no rsp_stb; following request 0x3F800000+0x3F800000 → 0x40000000.
REQ-038 NaN pass-through: A=0x7FC00000, B=0x3F800000 → rsp_z=0xFFC00000 (adder's canonical NaN).
